// File: rtl/oh_scanctrl.sv
// oh_scanctrl: scan-chain shift controller.
// Accepts one shift command at a time, drives se/si into an inverting scan
// chain for len cycles while collecting the chain's scan-out into a result
// word, then presents that word on a valid/ready output until it is taken.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in DONE and stays high with out_data stable until out_ready.
module oh_scanctrl #(
    parameter int CW     = 32,
    parameter int LW     = $clog2(CW + 1),
    parameter bit SI_INV = 1'b0,
    parameter bit SO_INV = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    input  logic [LW-1:0] in_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_data,
    output logic          se,
    output logic          si,
    input  logic          so,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_load;       // remaining load bits, bit 0 is next to drive
    logic [LW-1:0] r_len;        // clamped shift length of the active command
    logic [LW-1:0] r_cnt;        // index of the current shift cycle
    logic [CW-1:0] r_data;       // captured scan-out bits
    logic          r_se;
    logic          r_si;
    logic          r_out_valid;
    logic          r_busy;

    logic [LW-1:0] w_len_clamped;
    logic          w_last;
    logic          w_so_bit;
    logic [CW-1:0] w_bit_mask;

    // Requested lengths beyond the chain length are limited to the chain length
    always_comb begin
        w_len_clamped = in_len;
        if (in_len > LW'(CW)) begin
            w_len_clamped = LW'(CW);
        end
    end

    // Shift-cycle decode: last-cycle flag and the result bit for this cycle
    always_comb begin
        w_last     = (r_cnt == (r_len - LW'(1)));
        w_so_bit   = so ^ SO_INV;
        w_bit_mask = CW'(1) << r_cnt;
    end

    // Control FSM with all outputs registered; reset aborts any shift at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_load      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_se        <= 1'b0;
            r_si        <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // bit 0 goes out straight away, the rest waits in r_load
                        r_load <= in_data >> 1;
                        r_len  <= w_len_clamped;
                        r_cnt  <= '0;
                        r_data <= '0;
                        r_busy <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_se    <= 1'b1;
                            r_si    <= in_data[0] ^ SI_INV;
                        end
                    end
                end

                S_SHIFT: begin
                    // so is sampled on the same edge that shifts the chain,
                    // so it still reflects the last flop before this shift
                    if (w_so_bit) begin
                        r_data <= r_data | w_bit_mask;
                    end
                    r_load <= r_load >> 1;
                    if (w_last) begin
                        r_se        <= 1'b0;
                        r_si        <= 1'b0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + LW'(1);
                        r_si  <= r_load[0] ^ SI_INV;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_se        <= 1'b0;
                    r_si        <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign se        = r_se;
    assign si        = r_si;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_oh_scanctrl.sv
// Directed bench for oh_scanctrl with CW=8 driving a modelled chain of eight
// inverting scan flops (qn <= se ? ~si : ~d). The chain is preloaded by holding
// d at the complement of the wanted content while se is low.
module tb_oh_scanctrl;

    localparam int CW = 8;
    localparam int LW = $clog2(CW + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [CW-1:0] in_data;
    logic [LW-1:0] in_len;
    logic          out_ready;
    logic [CW-1:0] d;
    logic [CW-1:0] chain;
    logic          so;

    logic          in_ready0, out_valid0, se0, si0, busy0;
    logic [CW-1:0] out_data0;
    logic [1:0]    dbg0;
    logic          in_ready1, out_valid1, se1, si1, busy1;
    logic [CW-1:0] out_data1;
    logic [1:0]    dbg1;

    int checks;
    int errors;
    int cyc;
    int se_cnt;
    logic [CW-1:0] exp_q[$];

    oh_scanctrl #(.CW(CW), .SI_INV(1'b0), .SO_INV(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_len(in_len), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .se(se0), .si(si0),
        .so(so), .busy(busy0), .dbg_state(dbg0)
    );

    // Same stimulus and same scan-out, result inverted on capture
    oh_scanctrl #(.CW(CW), .SI_INV(1'b0), .SO_INV(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_len(in_len), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .se(se1), .si(si1),
        .so(so), .busy(busy1), .dbg_state(dbg1)
    );

    // clock / cycle counter / se-cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (se0) se_cnt <= se_cnt + 1;

    // chain model: stage 0 takes si, last stage drives so
    always @(posedge clk) chain <= se0 ? ~{chain[CW-2:0], si0} : ~d;
    assign so = chain[CW-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [LW-1:0] len, input logic [CW-1:0] data);
        in_valid = 1'b1;
        in_len   = len;
        in_data  = data;
        se_cnt   = 0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!out_valid0 && n < 40) begin
            step();
            n = n + 1;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_low"}, out_valid0, 1'b0);
        chk({tag, "_ready"}, in_ready0, 1'b1);
        chk({tag, "_busy_low"}, busy0, 1'b0);
    endtask

    initial begin
        int t[3];
        int got;
        int guard;
        logic [CW-1:0] e;
        checks = 0; errors = 0; cyc = 0; se_cnt = 0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0;
        out_ready = 1'b0; d = ~8'hA5;

        // reset state
        repeat (3) step();
        chk("rst_se", se0, 1'b0);
        chk("rst_si", si0, 1'b0);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out_data", out_data0, 8'h00);
        chk("rst_busy", busy0, 1'b0);
        reset = 1'b0;
        step();
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_state", dbg0, 2'd0);

        // full-length shift, chain preloaded A5, load 3C
        exp_q.push_back(8'h0F);
        issue(4'd8, 8'h3C);
        chk("t1_se_on", se0, 1'b1);
        chk("t1_si0", si0, 1'b0);
        chk("t1_in_ready", in_ready0, 1'b0);
        chk("t1_busy", busy0, 1'b1);
        wait_valid("t1_latency", 8);
        chk("t1_se_cycles", se_cnt, 8);
        e = exp_q.pop_front();
        chk("t1_out_data", out_data0, e);
        chk("t1_out_data_soinv", out_data1, 8'hF0);
        chk("t1_chain", chain, 8'h69);
        chk("t1_se_off", se0, 1'b0);
        chk("t1_state_done", dbg0, 2'd2);
        handshake("t1_hs");

        // zero length
        issue(4'd0, 8'hFF);
        chk("t2_valid", out_valid0, 1'b1);
        chk("t2_data", out_data0, 8'h00);
        chk("t2_se_cycles", se_cnt, 0);
        chk("t2_se", se0, 1'b0);
        handshake("t2_hs");

        // over-long length clamped to the chain length, chain preloaded FF
        d = 8'h00;
        step();
        issue(4'd15, 8'h00);
        wait_valid("t3_latency", 8);
        chk("t3_se_cycles", se_cnt, 8);
        chk("t3_data", out_data0, 8'h55);
        chk("t3_data_soinv", out_data1, 8'hAA);

        // result held under backpressure, new command waits for handshake
        in_valid = 1'b1; in_len = 4'd2; in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", out_valid0, 1'b1);
            chk("t4_hold_data", out_data0, 8'h55);
            chk("t4_hold_ready", in_ready0, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_not_yet", se0, 1'b0);
        chk("t4_ready_after", in_ready0, 1'b1);
        se_cnt = 0;
        step();
        in_valid = 1'b0;
        chk("t4_accepted_se", se0, 1'b1);
        chk("t4_accepted_busy", busy0, 1'b1);
        wait_valid("t4_latency", 2);
        chk("t4_data", out_data0, 8'h01);
        handshake("t4_hs");

        // reset during shift cycle 3
        d = ~8'hA5;
        step();
        issue(4'd8, 8'h3C);
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("t5_se_async", se0, 1'b0);
        chk("t5_valid", out_valid0, 1'b0);
        chk("t5_busy", busy0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk("t5_in_ready", in_ready0, 1'b1);
        chk("t5_data_cleared", out_data0, 8'h00);
        issue(4'd8, 8'h3C);
        wait_valid("t5_latency", 8);
        chk("t5_data", out_data0, 8'h0F);
        chk("t5_chain", chain, 8'h69);
        handshake("t5_hs");

        // back-to-back, len 4, chain preloaded FF each time
        d = 8'h00;
        step();
        in_valid = 1'b1; out_ready = 1'b1; in_len = 4'd4; in_data = 8'hFF;
        got = 0; guard = 0;
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h05);
        while (got < 3 && guard < 60) begin
            step();
            guard = guard + 1;
            if (out_valid0) begin
                t[got] = cyc;
                e = exp_q.pop_front();
                chk("t6_data", out_data0, e);
                chk("t6_data_soinv", out_data1, 8'h0A);
                got = got + 1;
            end
        end
        chk("t6_results", got, 3);
        if (got == 3) begin
            chk("t6_period_a", t[1] - t[0], 6);
            chk("t6_period_b", t[2] - t[1], 6);
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        chk("t6_idle", in_ready0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
